hgei_ctrl: RTL

Guest external interrupt controller for the hypervisor extension. It replaces the plain software-written hgeip flop with GEILEN live interrupt channels. Each channel has a synchronizer, level or edge capture, and a claim handshake. The block owns hgeie and derives hgeip, mip.SGEIP and the VSEIP selected by hstatus.VGEIN. It sits beside the H-mode CSR file in the privileged unit, and that file muxes its read values into CSR reads.

---
 rtl/hgei_ctrl_pkg.sv | 16 +
 rtl/hgei_chan.sv | 76 +++++++
 rtl/hgei_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/hgei_ctrl_pkg.sv
// Shared definitions for the guest external interrupt controller: CSR addresses,
// channel limits and the per-channel capture mode.
package hgei_ctrl_pkg;

    localparam logic [11:0] HGEIE_ADDR = 12'h607;
    localparam logic [11:0] HGEIP_ADDR = 12'hE12;

    localparam int XLEN_DEFAULT = 64;
    localparam int GEILEN_MAX   = XLEN_DEFAULT - 1;

    typedef enum logic {
        CHAN_LEVEL = 1'b0,
        CHAN_EDGE  = 1'b1
    } chan_mode_e;

endpackage

// File: rtl/hgei_chan.sv
// One guest external interrupt channel: synchronizer plus pending flop.
// Edge capture and claim-clear are built only when HGEI_EDGE_EN is defined.
module hgei_chan
    import hgei_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    input  logic edge_mode,
    input  logic claim_clr,
    output logic pend
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   pend_q, pend_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    end

`ifdef HGEI_EDGE_EN
    logic       s_dly_q, s_dly_d;
    chan_mode_e mode;

    assign mode = chan_mode_e'(edge_mode);

    // A fresh rising edge beats a same-cycle claim so no interrupt is lost.
    always_comb begin
        s_dly_d = s;
        pend_d  = s;
        if (mode == CHAN_EDGE) begin
            if (s && !s_dly_q) begin
                pend_d = 1'b1;
            end else if (claim_clr) begin
                pend_d = 1'b0;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_dly_q <= 1'b0;
        end else begin
            s_dly_q <= s_dly_d;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = edge_mode ^ claim_clr;

    always_comb begin
        pend_d = s;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/hgei_ctrl.sv
// Guest external interrupt controller: owns hgeie, derives hgeip, SGEIP and VSEIP
// from GEILEN live channels. HGEI_EDGE_EN enables per-channel edge capture.
module hgei_ctrl
    import hgei_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int GEILEN      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GEILEN-1:0] GuestExtIntIn,
    input  logic [GEILEN-1:0] GuestExtIntEdge,
    input  logic              CSRHWriteM,
    input  logic [11:0]       CSRAdrM,
    input  logic [XLEN-1:0]   CSRWriteValM,
    input  logic [5:0]        VGEINM,
    input  logic              ClaimValidM,
    input  logic [5:0]        ClaimIdM,
    output logic [XLEN-1:0]   HGEIEReadM,
    output logic [XLEN-1:0]   HGEIPReadM,
    output logic              SGEIPM,
    output logic              VSEIPM,
    output logic              ClaimAckM,
    output logic              IllegalCSRHGEIM
);

    // Bits 1..GEILEN; the shift saturates cleanly when GEILEN = XLEN-1.
    localparam logic [XLEN-1:0] HGEI_MASK = ~({XLEN{1'b1}} << (GEILEN + 1)) & ~XLEN'(1);

    logic [GEILEN-1:0] pend;
    logic [GEILEN-1:0] claim_clr;
    logic [XLEN-1:0]   hgeip;
    logic [XLEN-1:0]   hgeie_q, hgeie_d;
    logic              sgeip_q, sgeip_d;
    logic              vseip_q, vseip_d;
    logic              claim_ack_q, claim_ack_d;
    logic              claim_take;

    for (genvar g = 0; g < GEILEN; g++) begin : g_chan
        hgei_chan #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .raw_in    (GuestExtIntIn[g]),
            .edge_mode (GuestExtIntEdge[g]),
            .claim_clr (claim_clr[g]),
            .pend      (pend[g])
        );
    end

    // A claim arriving while the previous ack is still high is dropped.
    always_comb begin
        claim_take  = ClaimValidM & ~claim_ack_q;
        claim_ack_d = claim_take;
        for (int i = 0; i < GEILEN; i++) begin
            claim_clr[i] = claim_take && (ClaimIdM == 6'(i + 1));
        end
    end

    always_comb begin
        hgeip              = '0;
        hgeip[GEILEN:1]    = pend;
        hgeie_d            = hgeie_q;
        if (CSRHWriteM && (CSRAdrM == HGEIE_ADDR)) begin
            hgeie_d = CSRWriteValM & HGEI_MASK;
        end
        sgeip_d = |(hgeip & hgeie_q);
        vseip_d = 1'b0;
        for (int i = 1; i <= GEILEN; i++) begin
            if (VGEINM == 6'(i)) begin
                vseip_d = pend[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hgeie_q     <= '0;
            sgeip_q     <= 1'b0;
            vseip_q     <= 1'b0;
            claim_ack_q <= 1'b0;
        end else begin
            hgeie_q     <= hgeie_d;
            sgeip_q     <= sgeip_d;
            vseip_q     <= vseip_d;
            claim_ack_q <= claim_ack_d;
        end
    end

    always_comb begin
        HGEIEReadM      = hgeie_q;
        HGEIPReadM      = hgeip;
        SGEIPM          = sgeip_q;
        VSEIPM          = vseip_q;
        ClaimAckM       = claim_ack_q;
        IllegalCSRHGEIM = ~reset & CSRHWriteM & (CSRAdrM == HGEIP_ADDR);
    end

endmodule
